// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Build option: TT_SWEEP_SIGNATURE_EN enables the rolling sweep signature.
package tt_sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int          IN_BITS  = 4;
  localparam int          NUM_OUTS = 10;
  localparam logic [3:0]  LAST_IDX = 4'd15;

  // Reference response of the combinational stage, indexed by {w,x,y,z}.
  localparam logic [NUM_OUTS-1:0] GOLDEN [16] = '{
    10'h020, 10'h0A1, 10'h3C2, 10'h1F3,
    10'h044, 10'h2B5, 10'h1E6, 10'h307,
    10'h098, 10'h1A9, 10'h2DA, 10'h0FB,
    10'h36C, 10'h12D, 10'h25E, 10'h15F
  };

  // Counter preload for a settle window; 0 behaves as 1, clamped to 8 bits.
  function automatic logic [7:0] settle_load(input int cycles);
    if (cycles <= 1)
      return 8'd0;
    else if (cycles >= 255)
      return 8'd254;
    else
      return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Purpose: 8-bit loadable down-counter with zero flag for the settle window.
// Latency: load/decrement visible the cycle after the request.
// Backpressure: none; holds at zero until reloaded.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 8'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != 8'd0))
      cnt <= cnt - 8'd1;
  end

  assign zero = (cnt == 8'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: walks {w,x,y,z} through 0..15, captures f_in after a settle window, streams one row per combination.
// Latency: first row_valid SETTLE_CYCLES+1 cycles after start; done registered one cycle after the DONE state.
// Backpressure: row held stable in EMIT until row_ready; signature only with TT_SWEEP_SIGNATURE_EN.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                w,
  output logic                x,
  output logic                y,
  output logic                z,
  input  logic [NUM_OUTS-1:0] f_in,
  output logic                row_valid,
  input  logic                row_ready,
  output logic [3:0]          row_index,
  output logic [NUM_OUTS-1:0] row_outputs,
  output logic                done,
  output logic [NUM_OUTS-1:0] signature
);

  localparam logic [7:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

  state_t     state, state_n;
  logic [3:0] idx;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic       done_q;
  logic       row_hs;

  settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  assign row_hs = (state == EMIT) && row_ready;

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = SETTLE;
          tmr_load = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_zero)
          state_n = CAPTURE;
        else
          tmr_dec = 1'b1;
      end
      CAPTURE: state_n = EMIT;
      EMIT: begin
        if (row_ready) begin
          if (idx == LAST_IDX) begin
            state_n = DONE;
          end else begin
            state_n  = SETTLE;
            tmr_load = 1'b1;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 4'd0;
      row_index   <= 4'd0;
      row_outputs <= '0;
      done_q      <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= (state == DONE);
      if (state == IDLE && start)
        idx <= 4'd0;
      if (state == CAPTURE) begin
        row_outputs <= f_in;
        row_index   <= idx;
      end
      // Returning idx to 0 on the last row parks the stage inputs at 0 for DONE.
      if (row_hs)
        idx <= (idx == LAST_IDX) ? 4'd0 : idx + 4'd1;
    end
  end

`ifdef TT_SWEEP_SIGNATURE_EN
  logic [NUM_OUTS-1:0] sig_q;

  always_ff @(posedge clk) begin
    if (rst)
      sig_q <= '0;
    else if (state == IDLE && start)
      sig_q <= '0;
    else if (row_hs)
      sig_q <= {sig_q[NUM_OUTS-2:0], sig_q[NUM_OUTS-1]} ^ row_outputs;
  end

  assign signature = sig_q;
`else
  assign signature = '0;
`endif

  assign busy         = (state != IDLE);
  assign row_valid    = (state == EMIT);
  assign {w, x, y, z} = idx;
  assign done         = done_q;

endmodule
